pad_cfg_sequencer: RTL and testbench

- Run-time configuration controller for the padframe's bidirectional pads: holds the per-pad control word (drive strength, input enable, Schmitt trigger, pull enable/select, slew rate, output-enable permission).
- Applies configuration changes through a glitch-safe sequence: blank pad, wait, write, settle, release, so the pad never drives while its drive or pull settings change.
- Sits between the SoC register file (single request/ack port) and the padframe pad-cell control pins; core output enables are gated through it.

---
 rtl/pad_cfg_pkg.sv | 34 +++
 rtl/pad_cfg_reg.sv | 42 ++++
 rtl/pad_cfg_sequencer.sv | 139 +++++++++++++
 tb/tb_pad_cfg_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// Shared types for the pad configuration sequencer.
// Pad control word layout, reset default and FSM encoding.
package pad_cfg_pkg;

  typedef struct packed {
    logic [1:0] ds;
    logic       ie;
    logic       is;
    logic       pe;
    logic       ps;
    logic       sr;
    logic       oe_en;
  } pad_cfg_t;

  localparam pad_cfg_t PadCfgDefault = '{
    ds:    2'b00,
    ie:    1'b1,
    is:    1'b0,
    pe:    1'b1,
    ps:    1'b0,
    sr:    1'b0,
    oe_en: 1'b0
  };

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    BLANK,
    APPLY,
    SETTLE,
    DONE
  } state_e;

endpackage

// File: rtl/pad_cfg_reg.sv
// One pad's control register with output-enable / input-enable blanking.
// Blanking overrides the register so the pad is quiet while it changes.
module pad_cfg_reg
  import pad_cfg_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  pad_cfg_t cfg,
  input  logic     blank_oe,
  input  logic     blank_ie,
  input  logic     core_oe,
  output logic     oe,
  output logic     ie,
  output logic     ds0,
  output logic     ds1,
  output logic     pe,
  output logic     ps,
  output logic     is,
  output logic     sr
);

  pad_cfg_t cfg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= PadCfgDefault;
    end else if (we) begin
      cfg_q <= cfg;
    end
  end

  assign oe  = core_oe & cfg_q.oe_en & ~blank_oe;
  assign ie  = cfg_q.ie & ~blank_ie;
  assign ds0 = cfg_q.ds[0];
  assign ds1 = cfg_q.ds[1];
  assign pe  = cfg_q.pe;
  assign ps  = cfg_q.ps;
  assign is  = cfg_q.is;
  assign sr  = cfg_q.sr;

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Glitch-safe pad configuration sequencer: blank, apply, settle, release.
// One request in flight; the target pad is held quiet while it changes.
module pad_cfg_sequencer
  import pad_cfg_pkg::*;
#(
  parameter  int NumPads      = 16,
  parameter  int SettleCycles = 4,
  localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [IdxW-1:0]    req_idx_i,
  input  pad_cfg_t           req_cfg_i,
  output logic               done_o,
  output logic               err_o,
  output logic               busy_o,
  input  logic [NumPads-1:0] core_oe_i,
  output logic [NumPads-1:0] pad_oe_o,
  output logic [NumPads-1:0] pad_ie_o,
  output logic [NumPads-1:0] pad_ds0_o,
  output logic [NumPads-1:0] pad_ds1_o,
  output logic [NumPads-1:0] pad_pe_o,
  output logic [NumPads-1:0] pad_ps_o,
  output logic [NumPads-1:0] pad_is_o,
  output logic [NumPads-1:0] pad_sr_o
);

  localparam int CntW = $clog2(SettleCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(SettleCycles);

  state_e          state;
  state_e          state_n;
  logic [CntW-1:0] cnt;
  logic [IdxW-1:0] cap_idx;
  pad_cfg_t        cap_cfg;
  logic            accept;
  logic            idx_ok;
  logic            blank_oe;
  logic            blank_ie;
  logic            wr;

  assign accept = req_valid_i & req_ready_o;
  assign idx_ok = 32'(req_idx_i) < NumPads;
  assign wr     = (state == APPLY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = idx_ok ? BLANK : ERR;
      ERR:     state_n = IDLE;
      BLANK:   if (cnt == CntLast) state_n = APPLY;
      APPLY:   state_n = SETTLE;
      SETTLE:  if (cnt == CntLast) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = 1'b0;
    blank_oe    = 1'b0;
    blank_ie    = 1'b0;
    unique case (state)
      IDLE: req_ready_o = 1'b1;
      ERR:  err_o = 1'b1;
      BLANK, APPLY: begin
        busy_o   = 1'b1;
        blank_oe = 1'b1;
        blank_ie = 1'b1;
      end
      SETTLE: begin
        busy_o   = 1'b1;
        blank_oe = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter restarts on each state change and never runs past SettleCycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      cap_idx <= '0;
      cap_cfg <= PadCfgDefault;
    end else begin
      if (state_n != state) begin
        cnt <= '0;
      end else if (cnt != CntMax) begin
        cnt <= cnt + CntW'(1);
      end
      if (accept) begin
        cap_idx <= req_idx_i;
        cap_cfg <= req_cfg_i;
      end
    end
  end

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    logic hit;
    assign hit = (cap_idx == IdxW'(i));

    pad_cfg_reg u_reg (
      .clk      (clk_i),
      .rst      (rst_i),
      .we       (wr & hit),
      .cfg      (cap_cfg),
      .blank_oe (blank_oe & hit),
      .blank_ie (blank_ie & hit),
      .core_oe  (core_oe_i[i]),
      .oe       (pad_oe_o[i]),
      .ie       (pad_ie_o[i]),
      .ds0      (pad_ds0_o[i]),
      .ds1      (pad_ds1_o[i]),
      .pe       (pad_pe_o[i]),
      .ps       (pad_ps_o[i]),
      .is       (pad_is_o[i]),
      .sr       (pad_sr_o[i])
    );
  end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer with a phase-based reference model
// and a done-event scoreboard.
module tb_pad_cfg_sequencer;
  import pad_cfg_pkg::*;

  localparam int NP = 12;
  localparam int S  = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_idx = '0;
  pad_cfg_t      req_cfg = PadCfgDefault;
  logic          done, err, busy;
  logic [NP-1:0] core_oe = '1;
  logic [NP-1:0] p_oe, p_ie, p_ds0, p_ds1;
  logic [NP-1:0] p_pe, p_ps, p_is, p_sr;

  pad_cfg_sequencer #(
    .NumPads      (NP),
    .SettleCycles (S)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_idx_i   (req_idx),
    .req_cfg_i   (req_cfg),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .core_oe_i   (core_oe),
    .pad_oe_o    (p_oe),
    .pad_ie_o    (p_ie),
    .pad_ds0_o   (p_ds0),
    .pad_ds1_o   (p_ds1),
    .pad_pe_o    (p_pe),
    .pad_ps_o    (p_ps),
    .pad_is_o    (p_is),
    .pad_sr_o    (p_sr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       done_cyc;
    int       idx;
    pad_cfg_t cfg;
  } exp_t;

  exp_t     sb[$];
  pad_cfg_t m_cfg [NP];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  bit       act = 0;
  int       act_t = 0;
  int       act_idx = 0;
  pad_cfg_t act_cfg;
  bit       err_act = 0;
  int       acc_cnt = 0;
  int       last_acc = 0;
  int       done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check();
    logic [NP-1:0] e_oe, e_ie, e_ds0, e_ds1, e_pe, e_ps, e_is, e_sr;
    int d;
    pad_cfg_t c;
    bit tgt;
    exp_t e;
    d = cyc - act_t;
    for (int p = 0; p < NP; p++) begin
      c = m_cfg[p];
      tgt = act && (p == act_idx);
      e_oe[p]  = core_oe[p] & c.oe_en & ~(tgt && d >= 1 && d <= 2*S+1);
      e_ie[p]  = c.ie & ~(tgt && d >= 1 && d <= S+1);
      e_ds0[p] = c.ds[0];
      e_ds1[p] = c.ds[1];
      e_pe[p]  = c.pe;
      e_ps[p]  = c.ps;
      e_is[p]  = c.is;
      e_sr[p]  = c.sr;
    end
    chk("pad_oe", 32'(p_oe), 32'(e_oe));
    chk("pad_ie", 32'(p_ie), 32'(e_ie));
    chk("pad_ds0", 32'(p_ds0), 32'(e_ds0));
    chk("pad_ds1", 32'(p_ds1), 32'(e_ds1));
    chk("pad_pe", 32'(p_pe), 32'(e_pe));
    chk("pad_ps", 32'(p_ps), 32'(e_ps));
    chk("pad_is", 32'(p_is), 32'(e_is));
    chk("pad_sr", 32'(p_sr), 32'(e_sr));
    chk("ready", 32'(req_ready), 32'(!act && !err_act));
    chk("busy", 32'(busy), 32'(act));
    chk("err", 32'(err), 32'(err_act));
    chk("done", 32'(done), 32'(act && d == 2*S+2));
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow cyc=%0d got=done exp=none", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_cyc", 32'(cyc), 32'(e.done_cyc));
        chk("done_ds", 32'({p_ds1[e.idx], p_ds0[e.idx]}), 32'(e.cfg.ds));
        chk("done_pe", 32'(p_pe[e.idx]), 32'(e.cfg.pe));
        chk("done_sr", 32'(p_sr[e.idx]), 32'(e.cfg.sr));
        chk("done_oe", 32'(p_oe[e.idx]),
            32'(core_oe[e.idx] & e.cfg.oe_en));
      end
    end
  endtask

  task automatic step();
    bit acc;
    bit rst_now;
    acc = req_valid && !act && !err_act && !rst;
    rst_now = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      act = 0;
      err_act = 0;
      sb.delete();
      for (int p = 0; p < NP; p++) m_cfg[p] = PadCfgDefault;
    end else if (acc) begin
      acc_cnt++;
      last_acc = cyc - 1;
      if (int'(req_idx) < NP) begin
        act = 1;
        act_t = cyc - 1;
        act_idx = int'(req_idx);
        act_cfg = req_cfg;
        sb.push_back('{done_cyc: act_t + 2*S + 2,
                       idx: act_idx, cfg: req_cfg});
      end else begin
        err_act = 1;
      end
    end else begin
      err_act = 0;
    end
    if (act && cyc - act_t == S + 2) m_cfg[act_idx] = act_cfg;
    if (act && cyc - act_t > 2*S + 2) act = 0;
    check();
  endtask

  initial begin
    int t1;
    int n0;
    int dc;
    pad_cfg_t ca, cb;

    rst = 1'b1;
    core_oe = '1;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();

    // pad 3: strong drive, pull off, slow slew, output allowed
    req_valid = 1'b1;
    req_idx = 4'd3;
    req_cfg = '{ds: 2'b11, ie: 1'b1, is: 1'b0, pe: 1'b0,
                ps: 1'b0, sr: 1'b1, oe_en: 1'b1};
    step();
    req_valid = 1'b0;
    repeat (11) step();
    chk("p3_oe_live", 32'(p_oe[3]), 32'(1));

    // out-of-range indices, including the first one past the end
    req_valid = 1'b1;
    req_idx = 4'd12;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    req_valid = 1'b1;
    req_idx = 4'd15;
    step();
    req_valid = 1'b0;
    repeat (3) step();

    // back-to-back with valid held high
    ca = '{ds: 2'b01, ie: 1'b0, is: 1'b1, pe: 1'b1,
           ps: 1'b1, sr: 1'b0, oe_en: 1'b1};
    cb = '{ds: 2'b10, ie: 1'b1, is: 1'b0, pe: 1'b0,
           ps: 1'b1, sr: 1'b1, oe_en: 1'b0};
    dc = done_cnt;
    req_valid = 1'b1;
    req_idx = 4'd0;
    req_cfg = ca;
    step();
    t1 = last_acc;
    req_idx = 4'd1;
    req_cfg = cb;
    n0 = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == n0; k++) step();
    req_valid = 1'b0;
    chk("b2b_acc", 32'(acc_cnt), 32'(n0 + 1));
    chk("b2b_gap", 32'(last_acc - t1), 32'(11));
    repeat (12) step();
    chk("b2b_dones", 32'(done_cnt - dc), 32'(2));

    // reset in the middle of a sequence
    dc = done_cnt;
    req_valid = 1'b1;
    req_idx = 4'd2;
    req_cfg = ca;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("rst_nodone", 32'(done_cnt), 32'(dc));

    // pad 5: enable output, then rewrite the same word while toggling
    req_cfg = '{ds: 2'b01, ie: 1'b1, is: 1'b1, pe: 1'b0,
                ps: 1'b1, sr: 1'b0, oe_en: 1'b1};
    req_idx = 4'd5;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (11) step();
    dc = done_cnt;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      core_oe = NP'($urandom);
      core_oe[5] = k[0];
      step();
    end
    chk("same_cfg_done", 32'(done_cnt - dc), 32'(1));

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
